daq_readout_ctrl: RTL and testbench

Register-bus master that drains completed event pages from the DAQ multi-page event buffer and streams them out. It polls the DAQ status word, reads one event page word by word and presents it on a valid/ready stream with a last marker. It then advances the DAQ read pointer. It sits between the DAQ buffer's register port and the downstream event packer, replacing software polling.

---
 rtl/daq_pkg.sv | 36 +++
 rtl/daq_bus_master.sv | 126 ++++++++++++
 rtl/daq_readout_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_daq_readout_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/daq_pkg.sv
// Shared encodings, status-word layout and page-capacity helper for the DAQ readout controller.
package daq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_POLL = 3'd1,
        S_RD   = 3'd2,
        S_PUSH = 3'd3,
        S_ADV  = 3'd4,
        S_GAP  = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_WAIT = 2'd1,
        M_REL  = 2'd2
    } bus_state_t;

    localparam int EMPTY_BIT = 0;
    localparam int FULL_BIT  = 1;
    localparam int LEN_LSB   = 16;
    localparam int LEN_W     = 11;
    localparam int NEV_LSB   = 4;

    localparam logic [31:0] ADV_CMD = 32'h2;

    // Page size code 3 is reserved by the DAQ and behaves like code 2.
    function automatic logic [11:0] page_cap(input logic [1:0] page_size);
        case (page_size)
            2'd0:    page_cap = 12'd512;
            2'd1:    page_cap = 12'd1024;
            default: page_cap = 12'd2048;
        endcase
    endfunction

endpackage

// File: rtl/daq_bus_master.sv
// Single read or write transaction on the DAQ register port: strobe until ack,
// then wait for ack release before reporting done. Aborts after ACK_TIMEOUT cycles.
module daq_bus_master
    import daq_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        axi_clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [11:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic        o_rstr,
    output logic [11:0] o_raddr,
    input  logic        i_rack,
    input  logic [31:0] i_rdata,
    output logic        o_wstr,
    output logic [11:0] o_waddr,
    output logic [31:0] o_wdata,
    input  logic        i_wack
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LOAD = CW'(ACK_TIMEOUT - 1);

    bus_state_t      r_state;
    bus_state_t      w_state_nxt;
    logic            r_we;
    logic [CW-1:0]   r_wait_cnt;
    logic            r_rstr;
    logic [11:0]     r_raddr;
    logic            r_wstr;
    logic [11:0]     r_waddr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            w_ack;
    logic            w_launch;
    logic            w_capture;
    logic            w_abort;

    assign w_ack = r_we ? i_wack : i_rack;

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        o_done      = 1'b0;
        o_err       = 1'b0;
        case (r_state)
            M_IDLE: begin
                if (i_req) begin
                    w_launch    = 1'b1;
                    w_state_nxt = M_WAIT;
                end
            end
            M_WAIT: begin
                if (w_ack) begin
                    w_capture   = 1'b1;
                    w_state_nxt = M_REL;
                end else if (r_wait_cnt == '0) begin
                    w_abort     = 1'b1;
                    o_err       = 1'b1;
                    w_state_nxt = M_IDLE;
                end
            end
            // The DAQ keeps ack high one cycle past the strobe; a new strobe must not overlap it.
            M_REL: begin
                if (!w_ack) begin
                    o_done      = 1'b1;
                    w_state_nxt = M_IDLE;
                end
            end
            default: w_state_nxt = M_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= M_IDLE;
            r_we       <= 1'b0;
            r_wait_cnt <= '0;
            r_rstr     <= 1'b0;
            r_raddr    <= '0;
            r_wstr     <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch) begin
                r_we       <= i_we;
                r_wait_cnt <= TO_LOAD;
                r_rstr     <= !i_we;
                r_wstr     <= i_we;
                if (i_we) begin
                    r_waddr <= i_addr;
                    r_wdata <= i_wdata;
                end else begin
                    r_raddr <= i_addr;
                end
            end else if (r_state == M_WAIT) begin
                r_wait_cnt <= r_wait_cnt - CW'(1);
            end
            if (w_capture || w_abort) begin
                r_rstr <= 1'b0;
                r_wstr <= 1'b0;
            end
            if (w_capture && !r_we) begin
                r_rdata <= i_rdata;
            end
        end
    end

    assign o_rstr  = r_rstr;
    assign o_raddr = r_raddr;
    assign o_wstr  = r_wstr;
    assign o_waddr = r_waddr;
    assign o_wdata = r_wdata;
    assign o_rdata = r_rdata;

endmodule

// File: rtl/daq_readout_ctrl.sv
// Drains completed DAQ event pages over the register port and streams them out,
// advancing the DAQ read pointer after each event.
//
// state  | meaning
// IDLE   | stopped, waiting for enable
// POLL   | reading the status word
// RD     | reading event word idx from the current page
// PUSH   | presenting the captured word on the stream
// ADV    | writing advance_read to the command word
// GAP    | idle spacing between polls of an empty buffer
module daq_readout_ctrl
    import daq_pkg::*;
#(
    parameter int unsigned POLL_GAP    = 16,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter logic [11:0] STS_ADDR    = 12'h041,
    parameter logic [11:0] CMD_ADDR    = 12'h001,
    parameter logic [11:0] DATA_BASE   = 12'h800
) (
    input  logic        axi_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  page_size,
    output logic        bus_rstr,
    output logic [11:0] bus_raddr,
    input  logic        bus_rack,
    input  logic [31:0] bus_rdata,
    output logic        bus_wstr,
    output logic [11:0] bus_waddr,
    output logic [31:0] bus_wdata,
    input  logic        bus_wack,
    output logic [31:0] m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic [15:0] events_done,
    output logic        clipped,
    output logic        timeout_err,
    output logic        busy
);

    localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP);

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;
    logic [10:0] r_idx;
    logic [10:0] w_idx_nxt;
    logic [11:0] r_lim;
    logic [11:0] w_lim_nxt;
    logic [15:0] r_gap_cnt;
    logic [15:0] w_gap_nxt;
    logic [15:0] r_events_done;
    logic [15:0] w_events_nxt;
    logic        r_clipped;
    logic        w_clipped_nxt;
    logic        r_timeout_err;
    logic        w_timeout_nxt;

    logic        w_req;
    logic        w_we;
    logic [11:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_done;
    logic        w_err;
    logic [31:0] w_rdata;
    logic [11:0] w_len;
    logic [11:0] w_cap;
    logic        w_last;

    daq_bus_master #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_bus (
        .axi_clk (axi_clk),
        .reset_n (reset_n),
        .i_req   (w_req),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_done  (w_done),
        .o_err   (w_err),
        .o_rdata (w_rdata),
        .o_rstr  (bus_rstr),
        .o_raddr (bus_raddr),
        .i_rack  (bus_rack),
        .i_rdata (bus_rdata),
        .o_wstr  (bus_wstr),
        .o_waddr (bus_waddr),
        .o_wdata (bus_wdata),
        .i_wack  (bus_wack)
    );

    assign w_len  = {1'b0, w_rdata[LEN_LSB +: LEN_W]};
    assign w_cap  = page_cap(page_size);
    assign w_last = ({1'b0, r_idx} == (r_lim - 12'd1));

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_lim_nxt     = r_lim;
        w_gap_nxt     = r_gap_cnt;
        w_events_nxt  = r_events_done;
        w_clipped_nxt = r_clipped;
        w_timeout_nxt = r_timeout_err;
        w_req         = 1'b0;
        w_we          = 1'b0;
        w_addr        = STS_ADDR;
        w_wdata       = '0;
        case (r_state)
            S_IDLE: begin
                if (enable) w_state_nxt = S_POLL;
            end
            S_POLL: begin
                w_req = 1'b1;
                if (w_done) begin
                    if (w_rdata[EMPTY_BIT]) begin
                        w_gap_nxt   = GAP_LOAD;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_idx_nxt = '0;
                        if (w_len > w_cap) begin
                            w_lim_nxt     = w_cap;
                            w_clipped_nxt = 1'b1;
                        end else begin
                            w_lim_nxt = w_len;
                        end
                        w_state_nxt = (w_len == '0) ? S_ADV : S_RD;
                    end
                end
            end
            S_RD: begin
                w_req  = 1'b1;
                w_addr = DATA_BASE + {1'b0, r_idx};
                if (w_done) w_state_nxt = S_PUSH;
            end
            S_PUSH: begin
                if (m_ready) begin
                    if (w_last) begin
                        w_state_nxt = S_ADV;
                    end else begin
                        w_idx_nxt   = r_idx + 11'd1;
                        w_state_nxt = S_RD;
                    end
                end
            end
            // A drained event skips the poll gap so back-to-back events run at full rate.
            S_ADV: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_addr  = CMD_ADDR;
                w_wdata = ADV_CMD;
                if (w_done) begin
                    w_events_nxt = r_events_done + 16'd1;
                    w_state_nxt  = enable ? S_POLL : S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap_cnt <= 16'd1) begin
                    w_state_nxt = enable ? S_POLL : S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A lost ack abandons the whole event: no last marker, no advance.
        if (w_err) begin
            w_timeout_nxt = 1'b1;
            w_gap_nxt     = GAP_LOAD;
            w_state_nxt   = S_GAP;
        end
    end

    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_lim         <= '0;
            r_gap_cnt     <= '0;
            r_events_done <= '0;
            r_clipped     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_lim         <= w_lim_nxt;
            r_gap_cnt     <= w_gap_nxt;
            r_events_done <= w_events_nxt;
            r_clipped     <= w_clipped_nxt;
            r_timeout_err <= w_timeout_nxt;
        end
    end

    assign m_valid     = (r_state == S_PUSH);
    assign m_last      = m_valid && w_last;
    assign m_data      = m_valid ? w_rdata : '0;
    assign busy        = (r_state != S_IDLE);
    assign events_done = r_events_done;
    assign clipped     = r_clipped;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_daq_readout_ctrl.sv
// Bench for daq_readout_ctrl: DAQ register-port model, scoreboard-checked stream.
module tb_daq_readout_ctrl;

    localparam int POLL_GAP    = 16;
    localparam int ACK_TIMEOUT = 255;
    localparam logic [11:0] STS = 12'h041;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        axi_clk   = 1'b0;
    logic        reset_n   = 1'b1;
    logic        enable    = 1'b0;
    logic [1:0]  page_size = 2'd0;
    logic        bus_rstr;
    logic [11:0] bus_raddr;
    logic        bus_rack  = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_wstr;
    logic [11:0] bus_waddr;
    logic [31:0] bus_wdata;
    logic        bus_wack  = 1'b0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready   = 1'b0;
    logic [15:0] events_done;
    logic        clipped;
    logic        timeout_err;
    logic        busy;

    int          ready_mode = 0;
    logic        stuck      = 1'b0;
    int          posted     = 0;
    int          advanced   = 0;
    int          ev_len     = 0;
    logic [31:0] mem [0:2047];
    logic [31:0] status;

    int          cyc = 0;
    int          poll_cnt = 0, poll_interval = 0, last_poll_cyc = 0;
    int          rcnt = 0, wcnt = 0, rhigh_run = 0, last_run = 0;
    int          n_writes = 0;
    logic [11:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;

    int          words_seen = 0, stall_cnt = 0;
    int          n_checks = 0, n_pass = 0;
    exp_t        exp_q[$];
    logic        pv = 1'b0, pr = 1'b0;

    daq_readout_ctrl dut (
        .axi_clk     (axi_clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .page_size   (page_size),
        .bus_rstr    (bus_rstr),
        .bus_raddr   (bus_raddr),
        .bus_rack    (bus_rack),
        .bus_rdata   (bus_rdata),
        .bus_wstr    (bus_wstr),
        .bus_waddr   (bus_waddr),
        .bus_wdata   (bus_wdata),
        .bus_wack    (bus_wack),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .events_done (events_done),
        .clipped     (clipped),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 axi_clk = ~axi_clk;

    always @(posedge axi_clk) cyc++;

    always begin
        @(posedge axi_clk);
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = !m_ready;
            default: m_ready = 1'b0;
        endcase
    end

    assign status = (posted != advanced) ? {5'd0, 11'(ev_len), 16'h0010} : 32'h0000_0001;

    // DAQ register port: ack after 4 strobe cycles, released one cycle after the strobe drops.
    always @(negedge axi_clk) begin
        if (!reset_n) begin
            bus_rack = 1'b0; bus_wack = 1'b0;
            rcnt = 0; wcnt = 0; rhigh_run = 0;
        end else begin
            if (bus_rstr) begin
                if (rcnt == 0 && bus_raddr == STS) begin
                    if (poll_cnt > 0) poll_interval = cyc - last_poll_cyc;
                    last_poll_cyc = cyc;
                    poll_cnt++;
                end
                if (rcnt == 3 && !(stuck && bus_raddr != STS)) begin
                    bus_rack  = 1'b1;
                    bus_rdata = (bus_raddr == STS) ? status : mem[bus_raddr[10:0]];
                end
                rcnt++;
                rhigh_run++;
            end else begin
                if (rhigh_run > 0) last_run = rhigh_run;
                rhigh_run = 0;
                rcnt      = 0;
                bus_rack  = 1'b0;
                bus_rdata = 32'hDEAD_BEEF;
            end
            if (bus_wstr) begin
                if (wcnt == 3) begin
                    bus_wack   = 1'b1;
                    n_writes++;
                    last_waddr = bus_waddr;
                    last_wdata = bus_wdata;
                    if (bus_waddr == 12'h001 && bus_wdata == 32'h2) advanced++;
                end
                wcnt++;
            end else begin
                wcnt     = 0;
                bus_wack = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Stream monitor: every presented word must match the scoreboard head.
    always @(negedge axi_clk) begin
        if (!reset_n) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (pv && !pr) begin
                stall_cnt++;
                check("valid_hold", {31'd0, m_valid}, 32'd1);
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got %h expected no word", m_data);
                end else begin
                    check("m_data", m_data, exp_q[0].data);
                    check("m_last", {31'd0, m_last}, {31'd0, exp_q[0].last});
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        words_seen++;
                    end
                end
            end
            pv = m_valid;
            pr = m_ready;
        end
    end

    task automatic post_event(input int len, input int nexp, input logic [31:0] base);
        exp_t e;
        for (int i = 0; i < len; i++) mem[i] = base + 32'(i);
        for (int i = 0; i < nexp; i++) begin
            e.data = base + 32'(i);
            e.last = (i == nexp - 1);
            exp_q.push_back(e);
        end
        ev_len = len;
        posted++;
    endtask

    task automatic wait_events(input int target, input int budget);
        for (int i = 0; i < budget && events_done != 16'(target); i++) @(negedge axi_clk);
        check("events_done", {16'd0, events_done}, 32'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0, p0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge axi_clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_mvalid", {31'd0, m_valid}, 0);
        check("rst_strobes", {30'd0, bus_rstr, bus_wstr}, 0);
        check("rst_events", {16'd0, events_done}, 0);
        check("rst_flags", {30'd0, clipped, timeout_err}, 0);
        check("rst_raddr", {20'd0, bus_raddr}, 0);
        reset_n = 1'b1;

        // Empty buffer: periodic polls only.
        enable = 1'b1;
        repeat (100) @(negedge axi_clk);
        check("t1_polls", {31'd0, poll_cnt >= 3}, 1);
        check("t1_poll_period", {31'd0, poll_interval >= POLL_GAP + 4 && poll_interval <= POLL_GAP + 10}, 1);
        check("t1_no_writes", 32'(n_writes), 0);
        check("t1_no_words", 32'(words_seen), 0);
        check("t1_busy", {31'd0, busy}, 1);

        // Three-word event, ready always high.
        post_event(3, 3, 32'hA000_0000);
        wait_events(1, 600);
        check("t2_writes", 32'(n_writes), 1);
        check("t2_waddr", {20'd0, last_waddr}, 32'h001);
        check("t2_wdata", last_wdata, 32'h2);
        check("t2_words", 32'(words_seen), 3);

        // Same shape with ready toggling.
        ready_mode = 1;
        post_event(3, 3, 32'hB000_0010);
        wait_events(2, 600);
        check("t3_stalls", {31'd0, stall_cnt > 0}, 1);
        check("t3_words", 32'(words_seen), 6);
        check("t3_clip_clear", {31'd0, clipped}, 0);

        // Oversize event clipped to a 512-word page.
        ready_mode = 0;
        page_size  = 2'd0;
        w0 = words_seen;
        post_event(600, 512, 32'hC000_0000);
        wait_events(3, 8000);
        check("t4_words", 32'(words_seen - w0), 512);
        check("t4_clipped", {31'd0, clipped}, 1);
        check("t4_writes", 32'(n_writes), 3);

        // Read ack lost on the first data word.
        stuck = 1'b1;
        w0 = words_seen;
        post_event(2, 2, 32'hD000_0000);
        for (int i = 0; i < 1500 && !timeout_err; i++) @(negedge axi_clk);
        check("t5_timeout", {31'd0, timeout_err}, 1);
        repeat (2) @(negedge axi_clk);
        check("t5_strobe_len", 32'(last_run), ACK_TIMEOUT);
        check("t5_no_adv", {16'd0, events_done}, 3);
        check("t5_no_words", 32'(words_seen - w0), 0);
        check("t5_no_write", 32'(n_writes), 3);
        stuck = 1'b0;
        wait_events(4, 1500);
        check("t5_words", 32'(words_seen - w0), 2);
        check("t5_sticky", {31'd0, timeout_err}, 1);

        // enable dropped while the second word is in flight.
        w0 = words_seen;
        post_event(4, 4, 32'hE000_0100);
        for (int i = 0; i < 600 && words_seen == w0; i++) @(negedge axi_clk);
        enable = 1'b0;
        wait_events(5, 800);
        repeat (3) @(negedge axi_clk);
        check("t6_words", 32'(words_seen - w0), 4);
        check("t6_writes", 32'(n_writes), 5);
        check("t6_idle", {31'd0, busy}, 0);
        p0 = poll_cnt;
        repeat (60) @(negedge axi_clk);
        check("t6_no_polls", 32'(poll_cnt - p0), 0);

        // Reset while a word is held in PUSH.
        ready_mode = 2;
        post_event(1, 1, 32'hF000_0000);
        enable = 1'b1;
        for (int i = 0; i < 300 && !m_valid; i++) @(negedge axi_clk);
        check("t7_in_push", {31'd0, m_valid}, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t7_mvalid", {30'd0, m_valid, m_last}, 0);
        check("t7_mdata", m_data, 0);
        check("t7_busy", {31'd0, busy}, 0);
        check("t7_events", {16'd0, events_done}, 0);
        check("t7_flags", {30'd0, clipped, timeout_err}, 0);
        exp_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
